// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared FSM encoding and default parameters for register_bank
package register_bank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int          DEF_XLEN       = 32;
    localparam int          DEF_NREGS      = 32;
    localparam int          DEF_READ_PORTS = 2;
    localparam int          DEF_SP_INDEX   = 2;
    localparam logic [31:0] DEF_SP_RESET   = 32'h000000ff;
    localparam bit          DEF_BYPASS     = 1'b1;

endpackage

// File: rtl/register_bank_read_port.sv
// register_bank_read_port: one combinational read port with x0 zeroing, forwarding and clear masking
module register_bank_read_port #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            run,
    input  logic            wr_en,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] data
);

    // zero outside RUN and for x0; otherwise forward a same-cycle write when enabled
    always_comb begin
        data = (!run || addr == '0) ? '0
             : (BYPASS && wr_en && addr == rd) ? wdata
             : reg_data;
    end

endmodule

// File: rtl/register_bank.sv
// register_bank: multi-port register file that self-clears after reset before accepting writes
module register_bank
    import register_bank_pkg::*;
#(
    parameter int              XLEN       = DEF_XLEN,
    parameter int              NREGS      = DEF_NREGS,
    parameter int              READ_PORTS = DEF_READ_PORTS,
    parameter int              SP_INDEX   = DEF_SP_INDEX,
    parameter logic [XLEN-1:0] SP_RESET   = XLEN'(DEF_SP_RESET),
    parameter bit              BYPASS     = DEF_BYPASS,
    localparam int             AW         = $clog2(NREGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       writeRegister,
    input  logic [AW-1:0]              rd,
    input  logic [XLEN-1:0]            dataToWrite,
    input  logic [READ_PORTS*AW-1:0]   rsAddr,
    output logic [READ_PORTS*XLEN-1:0] registerRead,
    output logic                       ready
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            run;

    // reset masks RUN immediately so outputs drop while reset is held
    always_comb begin
        run   = (state_q == RUN) && !reset;
        ready = run;
    end

    // clear walk writes one register per cycle; RUN takes the external write port
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we      = 1'b0;
        waddr   = rd;
        wdata   = dataToWrite;
        if (!reset && state_q == CLEAR) begin
            we    = 1'b1;
            waddr = idx_q;
            wdata = (idx_q == AW'(SP_INDEX)) ? SP_RESET : '0;
            if (idx_q == AW'(NREGS - 1)) state_d = RUN;
            else idx_d = idx_q + AW'(1);
        end else if (!reset) begin
            we = writeRegister && (rd != '0);
        end
    end

    // FSM state and clear index
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // register storage, no reset: the clear walk initialises it
    always_ff @(posedge clock) begin
        if (we) regs_q[waddr] <= wdata;
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        register_bank_read_port #(
            .XLEN  (XLEN),
            .AW    (AW),
            .BYPASS(BYPASS)
        ) u_rd (
            .addr    (rsAddr[g*AW +: AW]),
            .reg_data(regs_q[rsAddr[g*AW +: AW]]),
            .run     (run),
            .wr_en   (writeRegister),
            .rd      (rd),
            .wdata   (dataToWrite),
            .data    (registerRead[g*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed checks of clear sequence, writes, forwarding, reset restart and wide build
module tb_register_bank;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0;
    logic [4:0]    rd = '0;
    logic [31:0]   wdata = '0;
    logic [9:0]    rs = '0;
    logic [63:0]   out, out_nb;
    logic          ready, ready_nb;
    logic          wr_w = 1'b0;
    logic [3:0]    rd_w = '0;
    logic [63:0]   wdata_w = '0;
    logic [11:0]   rs_w = '0;
    logic [191:0]  out_w;
    logic          ready_w;
    int            nvec = 0;
    int            nerr = 0;

    always #5 clk = ~clk;

    register_bank dut (
        .clock(clk), .reset(reset), .writeRegister(wr), .rd(rd), .dataToWrite(wdata),
        .rsAddr(rs), .registerRead(out), .ready(ready)
    );

    register_bank #(.BYPASS(0)) dut_nb (
        .clock(clk), .reset(reset), .writeRegister(wr), .rd(rd), .dataToWrite(wdata),
        .rsAddr(rs), .registerRead(out_nb), .ready(ready_nb)
    );

    register_bank #(.XLEN(64), .NREGS(16), .READ_PORTS(3), .SP_RESET(64'hff)) dut_w (
        .clock(clk), .reset(reset), .writeRegister(wr_w), .rd(rd_w), .dataToWrite(wdata_w),
        .rsAddr(rs_w), .registerRead(out_w), .ready(ready_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr = 1'b0;
        rs = {5'd2, 5'd2};
        step();
        #1;
        nvec++;
        if (ready !== 1'b0 || out !== 64'h0) begin
            nerr++;
            $display("FAIL reset_hold: ready=%b out=%h, want ready=0 out=0", ready, out);
        end
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            nvec++;
            if (ready !== (i == 32)) begin
                nerr++;
                $display("FAIL ready_rise cycle %0d: ready=%b want %b", i, ready, i == 32);
            end
            nvec++;
            if (ready_w !== (i >= 16)) begin
                nerr++;
                $display("FAIL ready_w cycle %0d: ready_w=%b want %b", i, ready_w, i >= 16);
            end
            if (i == 5) begin
                nvec++;
                if (out !== 64'h0) begin
                    nerr++;
                    $display("FAIL clear_read_mask: out=%h want 0", out);
                end
            end
        end
        for (int r = 0; r < 32; r++) begin
            logic [31:0] exp;
            rs = {5'(r), 5'(r)};
            exp = (r == 2) ? 32'hff : 32'h0;
            #1;
            nvec++;
            if (out !== {exp, exp} || out_nb !== {exp, exp}) begin
                nerr++;
                $display("FAIL clear_value x%0d: out=%h out_nb=%h want %h", r, out, out_nb, exp);
            end
        end
    endtask

    task automatic test_write_read();
        wr = 1'b1;
        rd = 5'd5;
        wdata = 32'hdeadbeef;
        step();
        wr = 1'b0;
        rs = {5'd0, 5'd5};
        #1;
        nvec++;
        if (out[31:0] !== 32'hdeadbeef || out_nb[31:0] !== 32'hdeadbeef) begin
            nerr++;
            $display("FAIL write_x5: got %h/%h want deadbeef", out[31:0], out_nb[31:0]);
        end
        wr = 1'b1;
        rd = 5'd0;
        wdata = 32'h1234;
        rs = {5'd0, 5'd0};
        #1;
        nvec++;
        if (out !== 64'h0) begin
            nerr++;
            $display("FAIL x0_fwd: out=%h want 0", out);
        end
        step();
        wr = 1'b0;
        #1;
        nvec++;
        if (out !== 64'h0 || out_nb !== 64'h0) begin
            nerr++;
            $display("FAIL x0_write: out=%h out_nb=%h want 0", out, out_nb);
        end
    endtask

    task automatic test_bypass();
        wr = 1'b1;
        rd = 5'd7;
        wdata = 32'hcafe0001;
        rs = {5'd7, 5'd7};
        #1;
        nvec++;
        if (out !== 64'hcafe0001_cafe0001) begin
            nerr++;
            $display("FAIL bypass_same_cycle: out=%h want cafe0001cafe0001", out);
        end
        nvec++;
        if (out_nb !== 64'h0) begin
            nerr++;
            $display("FAIL nobypass_old: out_nb=%h want 0", out_nb);
        end
        step();
        wr = 1'b0;
        #1;
        nvec++;
        if (out_nb[63:32] !== 32'hcafe0001 || out[63:32] !== 32'hcafe0001) begin
            nerr++;
            $display("FAIL bypass_next_cycle: out=%h out_nb=%h want cafe0001", out[63:32], out_nb[63:32]);
        end
    endtask

    task automatic test_wide();
        wr_w = 1'b1;
        rd_w = 4'd9;
        wdata_w = 64'h0123456789abcdef;
        step();
        wr_w = 1'b0;
        rs_w = {3{4'd9}};
        #1;
        for (int p = 0; p < 3; p++) begin
            nvec++;
            if (out_w[p*64 +: 64] !== 64'h0123456789abcdef) begin
                nerr++;
                $display("FAIL wide_port%0d: got %h want 0123456789abcdef", p, out_w[p*64 +: 64]);
            end
        end
        rs_w = {4'd2, 4'd0, 4'd1};
        #1;
        nvec++;
        if (out_w !== {64'hff, 64'h0, 64'h0}) begin
            nerr++;
            $display("FAIL wide_mixed: got %h want ff/0/0", out_w);
        end
    endtask

    task automatic test_clear_write_ignored();
        reset = 1'b1;
        wr = 1'b1;
        rd = 5'd3;
        wdata = 32'h55;
        rs = {5'd3, 5'd3};
        step();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 10) begin
                nvec++;
                if (out !== 64'h0) begin
                    nerr++;
                    $display("FAIL clear_fwd_mask: out=%h want 0", out);
                end
            end
        end
        wr = 1'b0;
        nvec++;
        if (ready !== 1'b1) begin
            nerr++;
            $display("FAIL clear_wr_ready: ready=%b want 1", ready);
        end
        #1;
        nvec++;
        if (out !== 64'h0 || out_nb !== 64'h0) begin
            nerr++;
            $display("FAIL clear_wr_ignored x3: out=%h out_nb=%h want 0", out, out_nb);
        end
    endtask

    task automatic test_reset_mid_clear();
        wr = 1'b1;
        rd = 5'd20;
        wdata = 32'h20202020;
        step();
        wr = 1'b0;
        rs = {5'd20, 5'd20};
        #1;
        nvec++;
        if (out !== 64'h20202020_20202020) begin
            nerr++;
            $display("FAIL x20_write: out=%h want 2020202020202020", out);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (ready !== 1'b0 || out !== 64'h0) begin
            nerr++;
            $display("FAIL reset_mask_run: ready=%b out=%h want 0/0", ready, out);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        nvec++;
        if (ready !== 1'b0) begin
            nerr++;
            $display("FAIL mid_clear_ready: ready=%b want 0", ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            nvec++;
            if (ready !== (i == 32)) begin
                nerr++;
                $display("FAIL restart_ready cycle %0d: ready=%b want %b", i, ready, i == 32);
            end
        end
        #1;
        nvec++;
        if (out !== 64'h0 || out_nb !== 64'h0) begin
            nerr++;
            $display("FAIL x20_cleared: out=%h out_nb=%h want 0", out, out_nb);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_wide();
        test_clear_write_ignored();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
